control_p4_responder: RTL and testbench
=======================================

CONTROL_P4_RESPONDER -- requirements
Module: control_p4_responder

Interface
REQ-001 SHALL have parameter C_BASE_ADDRESS, default 32'h00000000, window base XORed with incoming addresses.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, address width.
REQ-004 SHALL have parameter C_ID, default 32'h50345642, value of the ID register.
REQ-005 SHALL have S_AXI_ACLK  in  1  sole clock; one clock, all logic on its rising edge.
REQ-006 SHALL have S_AXI_ARESET  in  1  reset; synchronous, active-high.
REQ-007 SHALL have AXI4-Lite slave write ports: S_AXI_AWADDR in ADDR_W, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1, S_AXI_WDATA in 32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1, S_AXI_BRESP out 2, S_AXI_BVALID out 1, S_AXI_BREADY in 1.
REQ-008 SHALL have AXI4-Lite slave read ports: S_AXI_ARADDR in ADDR_W, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1, S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1.
REQ-009 SHALL have vswitch_en  out  2  per-virtual-switch enable, equal to CTRL[1:0].

Function
REQ-010 Offset SHALL be addr ^ C_BASE_ADDRESS; register index SHALL be offset[4:2]; offset >= 0x1C SHALL be unmapped.
REQ-011 Map: 0x00 ID RO = C_ID; 0x04 VERSION RO = 32'h00000001; 0x08 CTRL RW; 0x0C SCRATCH RW; 0x10 WR_COUNT RO; 0x14 RD_COUNT RO; 0x18 ERR_COUNT RO.
REQ-012 CTRL SHALL hold bits [1:0] enables; bit 8 is CLEAR, self-clearing and always read 0; other bits read 0.
REQ-013 Write FSM SHALL have states W_IDLE, W_ACK and W_RESP.
REQ-014 W_IDLE -> W_ACK SHALL occur when AWVALID and WVALID are both high; one valid alone SHALL keep W_IDLE.
REQ-015 In W_ACK, AWREADY and WREADY SHALL be high for exactly that cycle and the write SHALL commit; the FSM SHALL then go to W_RESP.
REQ-016 In W_RESP, BVALID SHALL be high with BRESP held stable until BREADY; the FSM SHALL then return to W_IDLE; minimum AW/W-valid to BVALID latency is 2 cycles.
REQ-017 Read FSM SHALL have states R_IDLE, R_ACK and R_DATA.
REQ-018 R_IDLE -> R_ACK SHALL occur on ARVALID; in R_ACK, ARREADY SHALL be high for one cycle and RDATA/RRESP SHALL be captured.
REQ-019 In R_DATA, RVALID, RDATA and RRESP SHALL be held stable until RREADY; the FSM SHALL then return to R_IDLE.
REQ-020 The read and write FSMs SHALL be independent and may be active concurrently.
REQ-021 WSTRB[i] SHALL gate byte i of RW register writes; WSTRB=0 SHALL be an OKAY no-op.
REQ-022 A write to an RO register SHALL respond OKAY and be ignored.
REQ-023 Unmapped read or write SHALL respond SLVERR (2'b10), with RDATA=0 and no state change.
REQ-024 Mapped accesses SHALL respond OKAY (2'b00).
REQ-025 WR_COUNT SHALL +1 per committed OKAY write; RD_COUNT SHALL +1 per captured OKAY read; ERR_COUNT SHALL +1 per SLVERR; same-cycle read and write errors SHALL add 2.
REQ-026 All counters SHALL saturate at 32'hFFFFFFFF and never wrap.
REQ-027 Writing CTRL with CLEAR=1 (WSTRB[1] set) SHALL zero all three counters on the commit edge; clear SHALL win over any same-cycle increment; the clearing write itself SHALL NOT be counted.
REQ-028 A same-cycle read and write to the same register SHALL return the pre-write value.

Reset
REQ-029 While S_AXI_ARESET is high, both FSMs SHALL go to IDLE and AWREADY, WREADY, BVALID, ARREADY and RVALID SHALL be 0 by the next edge.
REQ-030 On reset, BRESP, RRESP, RDATA, SCRATCH and the counters SHALL be 0, and CTRL SHALL be 32'h00000003, giving vswitch_en=2'b11.
REQ-031 Reset mid-transaction SHALL abandon the transaction, with no response issued after reset release.

Structure
REQ-032 Shared package control_p4_pkg SHALL hold register offsets, reset values, RESP codes, the VERSION constant and FSM state encodings.
REQ-033 A single sub-module control_p4_sat_counter (32-bit saturating, inc 0..2, synchronous clear priority) SHALL be instantiated three times.

Verification
REQ-034 Read 0x00 after reset -> RDATA=32'h50345642, RRESP=OKAY, ARREADY 1 cycle after ARVALID, RVALID 2 cycles after ARVALID.
REQ-035 Write SCRATCH 32'hA5A5A5A5 with WSTRB=4'b0101, then read it back -> 32'h00A500A5; WR_COUNT=1, RD_COUNT=1.
REQ-036 Write 0x20 and read 0x1C -> both respond SLVERR, RDATA=0, ERR_COUNT=2, other counters unchanged.
REQ-037 Hold BREADY low 10 cycles after a write -> BVALID and BRESP stay stable, a second AW/W pair is not accepted, and it is accepted after the B handshake.
REQ-038 Force WR_COUNT to 32'hFFFFFFFF, write again -> it stays FFFFFFFF; write CTRL=32'h00000101 -> counters=0, CTRL reads 32'h00000001, vswitch_en=2'b01.
REQ-039 Assert reset while in W_RESP -> BVALID low next cycle, no response after release, CTRL=32'h3.

Source files
------------

// File: rtl/control_p4_pkg.sv
// rtl/control_p4_pkg.sv - shared constants and FSM encodings for the control_p4 register block
// Holds register offsets and indices, reset values, AXI response codes, the
// VERSION constant and the read/write FSM state encodings.
package control_p4_pkg;

   // Byte offsets of the register map; offsets at or above OFF_LIMIT are unmapped
   localparam logic [4:0] OFF_ID        = 5'h00;
   localparam logic [4:0] OFF_VERSION   = 5'h04;
   localparam logic [4:0] OFF_CTRL      = 5'h08;
   localparam logic [4:0] OFF_SCRATCH   = 5'h0C;
   localparam logic [4:0] OFF_WR_COUNT  = 5'h10;
   localparam logic [4:0] OFF_RD_COUNT  = 5'h14;
   localparam logic [4:0] OFF_ERR_COUNT = 5'h18;
   localparam logic [4:0] OFF_LIMIT     = 5'h1C;

   // Register index = offset[4:2]
   localparam logic [2:0] IDX_ID        = OFF_ID[4:2];
   localparam logic [2:0] IDX_VERSION   = OFF_VERSION[4:2];
   localparam logic [2:0] IDX_CTRL      = OFF_CTRL[4:2];
   localparam logic [2:0] IDX_SCRATCH   = OFF_SCRATCH[4:2];
   localparam logic [2:0] IDX_WR_COUNT  = OFF_WR_COUNT[4:2];
   localparam logic [2:0] IDX_RD_COUNT  = OFF_RD_COUNT[4:2];
   localparam logic [2:0] IDX_ERR_COUNT = OFF_ERR_COUNT[4:2];
   localparam logic [2:0] IDX_UNMAPPED  = OFF_LIMIT[4:2];

   localparam logic [31:0] VERSION_VALUE = 32'h00000001;
   localparam logic [31:0] CTRL_RESET    = 32'h00000003;
   localparam logic [31:0] SCRATCH_RESET = 32'h00000000;
   localparam int          CTRL_CLEAR_BIT = 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ACK  = 2'd1,
      W_RESP = 2'd2
   } w_state_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ACK  = 2'd1,
      R_DATA = 2'd2
   } r_state_t;

endpackage

// File: rtl/control_p4_responder_if.sv
// rtl/control_p4_responder_if.sv - AXI4-Lite slave bus bundle for control_p4_responder
// Carries the AW/W/B write channels and AR/R read channels. The slave modport
// is used by the register block, the master modport by whatever drives it.
interface control_p4_responder_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] S_AXI_AWADDR;
   logic              S_AXI_AWVALID;
   logic              S_AXI_AWREADY;
   logic [31:0]       S_AXI_WDATA;
   logic [3:0]        S_AXI_WSTRB;
   logic              S_AXI_WVALID;
   logic              S_AXI_WREADY;
   logic [1:0]        S_AXI_BRESP;
   logic              S_AXI_BVALID;
   logic              S_AXI_BREADY;
   logic [ADDR_W-1:0] S_AXI_ARADDR;
   logic              S_AXI_ARVALID;
   logic              S_AXI_ARREADY;
   logic [31:0]       S_AXI_RDATA;
   logic [1:0]        S_AXI_RRESP;
   logic              S_AXI_RVALID;
   logic              S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/control_p4_sat_counter.sv
// rtl/control_p4_sat_counter.sv - 32-bit saturating event counter with synchronous clear
// Ports: clk, rst (sync active-high), clear (sync, beats any increment),
//        inc (0..2 per cycle), count (current value, sticks at all-ones).
module control_p4_sat_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic [1:0]  inc,
   output logic [31:0] count
);
   logic [31:0] count_q;
   logic [32:0] sum;

   // One extra bit catches the carry out so the counter pins instead of wrapping
   assign sum = {1'b0, count_q} + {31'b0, inc};

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count_q <= '0;
      end else if (sum[32]) begin
         count_q <= '1;
      end else begin
         count_q <= sum[31:0];
      end
   end

   assign count = count_q;
endmodule

// File: rtl/control_p4_responder.sv
// rtl/control_p4_responder.sv - AXI4-Lite control/status register block with traffic counters
// Ports: S_AXI_ACLK (clock), S_AXI_ARESET (sync active-high reset),
//        s_axi (AXI4-Lite slave bundle), vswitch_en (CTRL[1:0] enables).
// Independent write (W_IDLE/W_ACK/W_RESP) and read (R_IDLE/R_ACK/R_DATA) FSMs.
module control_p4_responder
   import control_p4_pkg::*;
#(
   parameter logic [31:0] C_BASE_ADDRESS     = 32'h00000000,
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 32,
   parameter logic [31:0] C_ID               = 32'h50345642
) (
   input  logic                        S_AXI_ACLK,
   input  logic                        S_AXI_ARESET,
   control_p4_responder_if.slave       s_axi,
   output logic [1:0]                  vswitch_en
);
   localparam logic [C_S_AXI_ADDR_WIDTH-1:0] BASE = C_S_AXI_ADDR_WIDTH'(C_BASE_ADDRESS);

   w_state_t w_state, w_state_next;
   r_state_t r_state, r_state_next;

   logic [C_S_AXI_ADDR_WIDTH-1:0] w_offset, r_offset;
   logic [2:0]  w_idx, r_idx;
   logic        w_mapped, r_mapped;
   logic        w_commit, r_capture;
   logic        clear_counts;

   logic [1:0]  ctrl_en;
   logic [31:0] scratch;
   logic [31:0] wr_count, rd_count, err_count;
   logic [31:0] rd_mux;
   logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
   logic [1:0]  rresp_q, bresp_q;

   assign w_offset = s_axi.S_AXI_AWADDR ^ BASE;
   assign r_offset = s_axi.S_AXI_ARADDR ^ BASE;
   assign w_idx    = w_offset[4:2];
   assign r_idx    = r_offset[4:2];
   // offset < 0x1C: nothing above bit 4 and not the 0x1C..0x1F slot
   assign w_mapped = (w_offset[C_S_AXI_ADDR_WIDTH-1:5] == '0) && (w_idx != IDX_UNMAPPED);
   assign r_mapped = (r_offset[C_S_AXI_ADDR_WIDTH-1:5] == '0) && (r_idx != IDX_UNMAPPED);

   assign w_commit  = (w_state == W_ACK);
   assign r_capture = (r_state == R_ACK);

   // ---------------- write FSM ----------------
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) w_state <= W_IDLE;
      else              w_state <= w_state_next;
   end

   always_comb begin
      w_state_next        = w_state;
      s_axi.S_AXI_AWREADY = 1'b0;
      s_axi.S_AXI_WREADY  = 1'b0;
      s_axi.S_AXI_BVALID  = 1'b0;
      case (w_state)
         W_IDLE: if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) w_state_next = W_ACK;
         W_ACK: begin
            s_axi.S_AXI_AWREADY = 1'b1;
            s_axi.S_AXI_WREADY  = 1'b1;
            w_state_next        = W_RESP;
         end
         W_RESP: begin
            s_axi.S_AXI_BVALID = 1'b1;
            if (s_axi.S_AXI_BREADY) w_state_next = W_IDLE;
         end
         default: w_state_next = W_IDLE;
      endcase
   end

   // ---------------- read FSM ----------------
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) r_state <= R_IDLE;
      else              r_state <= r_state_next;
   end

   always_comb begin
      r_state_next        = r_state;
      s_axi.S_AXI_ARREADY = 1'b0;
      s_axi.S_AXI_RVALID  = 1'b0;
      case (r_state)
         R_IDLE: if (s_axi.S_AXI_ARVALID) r_state_next = R_ACK;
         R_ACK: begin
            s_axi.S_AXI_ARREADY = 1'b1;
            r_state_next        = R_DATA;
         end
         R_DATA: begin
            s_axi.S_AXI_RVALID = 1'b1;
            if (s_axi.S_AXI_RREADY) r_state_next = R_IDLE;
         end
         default: r_state_next = R_IDLE;
      endcase
   end

   // ---------------- register file ----------------
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         ctrl_en <= CTRL_RESET[1:0];
         scratch <= SCRATCH_RESET;
         bresp_q <= RESP_OKAY;
      end else if (w_commit) begin
         bresp_q <= w_mapped ? RESP_OKAY : RESP_SLVERR;
         if (w_mapped) begin
            case (w_idx)
               IDX_CTRL: if (s_axi.S_AXI_WSTRB[0]) ctrl_en <= s_axi.S_AXI_WDATA[1:0];
               IDX_SCRATCH: begin
                  for (int i = 0; i < 4; i++) begin
                     if (s_axi.S_AXI_WSTRB[i]) scratch[8*i +: 8] <= s_axi.S_AXI_WDATA[8*i +: 8];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // CLEAR lives in byte 1, so it only takes effect when that lane is strobed
   assign clear_counts = w_commit && w_mapped && (w_idx == IDX_CTRL) &&
                         s_axi.S_AXI_WSTRB[1] && s_axi.S_AXI_WDATA[CTRL_CLEAR_BIT];

   always_comb begin
      rd_mux = '0;
      case (r_idx)
         IDX_ID:        rd_mux = C_ID;
         IDX_VERSION:   rd_mux = VERSION_VALUE;
         IDX_CTRL:      rd_mux = {30'b0, ctrl_en};
         IDX_SCRATCH:   rd_mux = scratch;
         IDX_WR_COUNT:  rd_mux = wr_count;
         IDX_RD_COUNT:  rd_mux = rd_count;
         IDX_ERR_COUNT: rd_mux = err_count;
         default:       rd_mux = '0;
      endcase
      if (!r_mapped) rd_mux = '0;
   end

   // Captured from pre-edge register values, so a colliding write is not visible
   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         rdata_q <= '0;
         rresp_q <= RESP_OKAY;
      end else if (r_capture) begin
         rdata_q <= rd_mux;
         rresp_q <= r_mapped ? RESP_OKAY : RESP_SLVERR;
      end
   end

   // ---------------- counters ----------------
   control_p4_sat_counter u_wr_count (
      .clk   (S_AXI_ACLK),
      .rst   (S_AXI_ARESET),
      .clear (clear_counts),
      .inc   ({1'b0, w_commit && w_mapped}),
      .count (wr_count)
   );

   control_p4_sat_counter u_rd_count (
      .clk   (S_AXI_ACLK),
      .rst   (S_AXI_ARESET),
      .clear (clear_counts),
      .inc   ({1'b0, r_capture && r_mapped}),
      .count (rd_count)
   );

   control_p4_sat_counter u_err_count (
      .clk   (S_AXI_ACLK),
      .rst   (S_AXI_ARESET),
      .clear (clear_counts),
      .inc   ({1'b0, w_commit && !w_mapped} + {1'b0, r_capture && !r_mapped}),
      .count (err_count)
   );

   assign s_axi.S_AXI_BRESP = bresp_q;
   assign s_axi.S_AXI_RRESP = rresp_q;
   assign s_axi.S_AXI_RDATA = rdata_q;
   assign vswitch_en        = ctrl_en;
endmodule

// File: tb/tb_control_p4_responder.sv
// tb/tb_control_p4_responder.sv - directed self-checking bench for control_p4_responder
module tb_control_p4_responder;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] vswitch_en;
   int         n_checks = 0;
   int         n_errors = 0;

   control_p4_responder_if #(.ADDR_W(32)) bus ();

   control_p4_responder dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESET (rst),
      .s_axi        (bus),
      .vswitch_en   (vswitch_en)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output int lat);
      int cyc;
      @(negedge clk);
      bus.S_AXI_AWADDR  = addr;
      bus.S_AXI_WDATA   = data;
      bus.S_AXI_WSTRB   = strb;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WVALID  = 1'b1;
      bus.S_AXI_BREADY  = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!bus.S_AXI_AWREADY && cyc < 20);
      check_val("wr_awready", {31'b0, bus.S_AXI_AWREADY}, 32'd1);
      @(negedge clk);
      cyc++;
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      check_val("wr_bvalid", {31'b0, bus.S_AXI_BVALID}, 32'd1);
      resp = bus.S_AXI_BRESP;
      lat  = cyc;
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output int ar_lat, output int r_lat);
      int cyc;
      @(negedge clk);
      bus.S_AXI_ARADDR  = addr;
      bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_RREADY  = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!bus.S_AXI_ARREADY && cyc < 20);
      check_val("rd_arready", {31'b0, bus.S_AXI_ARREADY}, 32'd1);
      ar_lat = cyc;
      @(negedge clk);
      cyc++;
      bus.S_AXI_ARVALID = 1'b0;
      check_val("rd_rvalid", {31'b0, bus.S_AXI_RVALID}, 32'd1);
      data  = bus.S_AXI_RDATA;
      resp  = bus.S_AXI_RRESP;
      r_lat = cyc;
      @(negedge clk);
      bus.S_AXI_RREADY = 1'b0;
   endtask

   task automatic write_expect(input string tag, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [1:0] exp_resp);
      logic [1:0] r;
      int         l;
      axi_write(addr, data, strb, r, l);
      check_val({tag, "_bresp"}, {30'b0, r}, {30'b0, exp_resp});
   endtask

   task automatic read_expect(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                              input logic [1:0] exp_resp);
      logic [31:0] d;
      logic [1:0]  r;
      int          al, rl;
      axi_read(addr, d, r, al, rl);
      check_val({tag, "_data"}, d, exp_data);
      check_val({tag, "_rresp"}, {30'b0, r}, {30'b0, exp_resp});
   endtask

   logic [31:0] rdata_a;
   logic [1:0]  rresp_a, bresp_a;
   int          ar_lat, r_lat, w_lat, cyc;
   logic        bad, acc, seen;

   initial begin
      rst = 1'b1;
      bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WDATA = '0;
      bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 1'b0;  bus.S_AXI_BREADY = 1'b0;
      bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // reset state
      check_val("rst_handshakes", {27'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                                   bus.S_AXI_ARREADY, bus.S_AXI_RVALID}, 32'd0);
      check_val("rst_vswitch", {30'b0, vswitch_en}, 32'd3);
      check_val("rst_resp_data", {bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA[27:0]}, 32'd0);

      // strobed scratch write, minimum B latency
      axi_write(32'h0C, 32'hA5A5A5A5, 4'b0101, bresp_a, w_lat);
      check_val("scr_bresp", {30'b0, bresp_a}, 32'd0);
      check_val("wr_latency", 32'(w_lat), 32'd2);
      read_expect("scr_rd", 32'h0C, 32'h00A500A5, 2'b00);
      read_expect("wrcnt1", 32'h10, 32'd1, 2'b00);
      read_expect("rdcnt1", 32'h14, 32'd2, 2'b00);

      // ID read with handshake timing
      axi_read(32'h00, rdata_a, rresp_a, ar_lat, r_lat);
      check_val("id_data", rdata_a, 32'h50345642);
      check_val("id_rresp", {30'b0, rresp_a}, 32'd0);
      check_val("id_ar_lat", 32'(ar_lat), 32'd1);
      check_val("id_r_lat", 32'(r_lat), 32'd2);
      read_expect("version", 32'h04, 32'h00000001, 2'b00);
      read_expect("ctrl_rst", 32'h08, 32'h00000003, 2'b00);

      // RO write ignored, zero-strobe write is a no-op
      write_expect("ro_wr", 32'h00, 32'hFFFFFFFF, 4'hF, 2'b00);
      read_expect("id_after_wr", 32'h00, 32'h50345642, 2'b00);
      write_expect("strb0", 32'h08, 32'h00000000, 4'h0, 2'b00);
      read_expect("ctrl_strb0", 32'h08, 32'h00000003, 2'b00);

      // simultaneous unmapped write and read -> two errors in one cycle
      fork
         axi_write(32'h20, 32'h00000001, 4'hF, bresp_a, w_lat);
         axi_read(32'h1C, rdata_a, rresp_a, ar_lat, r_lat);
      join
      check_val("unm_bresp", {30'b0, bresp_a}, 32'd2);
      check_val("unm_rresp", {30'b0, rresp_a}, 32'd2);
      check_val("unm_rdata", rdata_a, 32'd0);
      read_expect("errcnt", 32'h18, 32'd2, 2'b00);
      read_expect("wrcnt3", 32'h10, 32'd3, 2'b00);
      read_expect("rdcnt10", 32'h14, 32'd10, 2'b00);

      // same-cycle read and write of SCRATCH returns the old value
      fork
         axi_write(32'h0C, 32'h12345678, 4'hF, bresp_a, w_lat);
         axi_read(32'h0C, rdata_a, rresp_a, ar_lat, r_lat);
      join
      check_val("collide_rdata", rdata_a, 32'h00A500A5);
      read_expect("scr_new", 32'h0C, 32'h12345678, 2'b00);

      // BREADY held low: response stable, next AW/W pair waits
      @(negedge clk);
      bus.S_AXI_AWADDR = 32'h0C; bus.S_AXI_WDATA = 32'h11111111; bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_AWVALID = 1'b1;  bus.S_AXI_WVALID = 1'b1;        bus.S_AXI_BREADY = 1'b0;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!bus.S_AXI_AWREADY && cyc < 20);
      @(negedge clk);
      bus.S_AXI_WDATA = 32'h22222222;
      check_val("bhold_bvalid", {31'b0, bus.S_AXI_BVALID}, 32'd1);
      bad = 1'b0; acc = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!bus.S_AXI_BVALID || bus.S_AXI_BRESP != 2'b00) bad = 1'b1;
         if (bus.S_AXI_AWREADY || bus.S_AXI_WREADY) acc = 1'b1;
      end
      check_val("bhold_stable", {31'b0, bad}, 32'd0);
      check_val("bhold_no_accept", {31'b0, acc}, 32'd0);
      bus.S_AXI_BREADY = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!bus.S_AXI_AWREADY && cyc < 20);
      check_val("second_accept_lat", 32'(cyc), 32'd2);
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      check_val("second_bvalid", {31'b0, bus.S_AXI_BVALID}, 32'd1);
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
      read_expect("scr_second", 32'h0C, 32'h22222222, 2'b00);

      // saturation, then CLEAR via CTRL
      @(negedge clk);
      force dut.u_wr_count.count_q = 32'hFFFFFFFF;
      repeat (2) @(negedge clk);
      release dut.u_wr_count.count_q;
      write_expect("sat_wr", 32'h0C, 32'h0, 4'hF, 2'b00);
      read_expect("wrcnt_sat", 32'h10, 32'hFFFFFFFF, 2'b00);
      write_expect("clr_wr", 32'h08, 32'h00000101, 4'hF, 2'b00);
      read_expect("ctrl_clr", 32'h08, 32'h00000001, 2'b00);
      check_val("vswitch_01", {30'b0, vswitch_en}, 32'd1);
      read_expect("wrcnt_clr", 32'h10, 32'd0, 2'b00);
      read_expect("rdcnt_clr", 32'h14, 32'd2, 2'b00);
      read_expect("errcnt_clr", 32'h18, 32'd0, 2'b00);

      // reset while the write FSM sits in W_RESP
      @(negedge clk);
      bus.S_AXI_AWADDR = 32'h08; bus.S_AXI_WDATA = 32'h0; bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_AWVALID = 1'b1;  bus.S_AXI_WVALID = 1'b1;  bus.S_AXI_BREADY = 1'b0;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!bus.S_AXI_AWREADY && cyc < 20);
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      check_val("mid_bvalid", {31'b0, bus.S_AXI_BVALID}, 32'd1);
      check_val("mid_vswitch", {30'b0, vswitch_en}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check_val("rst_bvalid_low", {31'b0, bus.S_AXI_BVALID}, 32'd0);
      rst = 1'b0;
      bus.S_AXI_BREADY = 1'b1;
      seen = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (bus.S_AXI_BVALID) seen = 1'b1;
      end
      check_val("no_resp_after_rst", {31'b0, seen}, 32'd0);
      bus.S_AXI_BREADY = 1'b0;
      read_expect("ctrl_after_rst", 32'h08, 32'h00000003, 2'b00);
      check_val("vswitch_after_rst", {30'b0, vswitch_en}, 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
